// File: rtl/gate_pkg.sv
// gate_pkg: shared state encoding and default sizing for the cymometer gate controller.
package gate_pkg;
    typedef enum logic [1:0] {IDLE, ARM, GATE, DONE} gate_state_t;
    localparam int DEF_CNT_W       = 32;
    localparam int DEF_GATE_W      = 16;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_TIMEOUT     = 50_000_000;
endpackage

// File: rtl/gate_if.sv
// gate_if: control/result bundle between a measurement host and gate_ctrl.
interface gate_if #(
    parameter int CNT_W  = gate_pkg::DEF_CNT_W,
    parameter int GATE_W = gate_pkg::DEF_GATE_W
);
    logic              clk_fx;
    logic              start;
    logic              cont;
    logic [GATE_W-1:0] gate_len;
    logic              busy;
    logic              gate;
    logic              done;
    logic [GATE_W-1:0] fx_result;
    logic [CNT_W-1:0]  fs_result;
    logic              ovf;
    logic              timeout;
    modport master (
        output clk_fx, start, cont, gate_len,
        input  busy, gate, done, fx_result, fs_result, ovf, timeout
    );
    modport slave (
        input  clk_fx, start, cont, gate_len,
        output busy, gate, done, fx_result, fs_result, ovf, timeout
    );
endinterface

// File: rtl/gate_ctrl_fx_edge_sync.sv
// fx_edge_sync: brings the asynchronous measured signal into the reference domain
// and flags each rising edge as a one-cycle pulse.
module fx_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic fx_i,
    output logic fx_rise_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], fx_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end
    assign fx_rise_o = sync_q[SYNC_STAGES-1] & ~hist_q;
endmodule

// File: rtl/gate_ctrl.sv
// gate_ctrl: gate generator and dual edge/reference counter for an equal-precision cymometer.
// Define GATE_TIMEOUT_EN to abort ARM/GATE after TIMEOUT cycles without a measured edge.
module gate_ctrl import gate_pkg::*; #(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int GATE_W      = DEF_GATE_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input logic   clk_fs,
    input logic   rst,
    gate_if.slave bus
);
    localparam logic [GATE_W-1:0] ONE_G = GATE_W'(1);
    localparam logic [CNT_W-1:0]  ONE_C = CNT_W'(1);

    gate_state_t       state_q, state_d;
    logic [GATE_W-1:0] len_q, len_d, fx_cnt_q, fx_cnt_d, fx_res_q, fx_res_d, len_in;
    logic [CNT_W-1:0]  fs_cnt_q, fs_cnt_d, fs_res_q, fs_res_d;
    logic              ovf_q, ovf_d, ovf_res_q, ovf_res_d;
    logic              busy_q, gate_q, done_q, timeout_q;
    logic              fx_rise, to_hit, fs_sat, close;

    fx_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk_fs),
        .rst       (rst),
        .fx_i      (bus.clk_fx),
        .fx_rise_o (fx_rise)
    );

    assign len_in = (bus.gate_len == '0) ? ONE_G : bus.gate_len;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        fx_cnt_d  = fx_cnt_q;
        fs_cnt_d  = fs_cnt_q;
        ovf_d     = ovf_q;
        fx_res_d  = fx_res_q;
        fs_res_d  = fs_res_q;
        ovf_res_d = ovf_res_q;
        fs_sat    = fs_cnt_q == '1;
        close     = state_q == GATE && fx_rise && (fx_cnt_q + ONE_G) == len_q;
        case (state_q)
            IDLE: if (bus.start) begin
                len_d   = len_in;
                state_d = ARM;
            end
            ARM: if (fx_rise) begin
                fx_cnt_d = '0;
                fs_cnt_d = '0;
                ovf_d    = 1'b0;
                state_d  = GATE;
            end
            GATE: begin
                // the closing cycle is still counted, so results take the incremented values
                fs_cnt_d = fs_sat ? fs_cnt_q : fs_cnt_q + ONE_C;
                ovf_d    = ovf_q | fs_sat;
                fx_cnt_d = fx_rise ? fx_cnt_q + ONE_G : fx_cnt_q;
                if (close) begin
                    fx_res_d  = fx_cnt_d;
                    fs_res_d  = fs_cnt_d;
                    ovf_res_d = ovf_d;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = bus.cont ? ARM : IDLE;
                len_d   = bus.cont ? len_in : len_q;
            end
        endcase
        if (to_hit) state_d = IDLE;
    end

`ifdef GATE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            waiting;
    always_comb begin
        waiting  = state_q == ARM || state_q == GATE;
        to_hit   = waiting && !fx_rise && to_cnt_q == TO_W'(TIMEOUT - 1);
        to_cnt_d = (!waiting || fx_rise || state_d != state_q) ? '0 : to_cnt_q + TO_W'(1);
    end
    always_ff @(posedge clk_fs or posedge rst) begin
        if (rst) to_cnt_q <= '0;
        else     to_cnt_q <= to_cnt_d;
    end
`else
    logic unused_timeout;
    assign to_hit         = 1'b0;
    assign unused_timeout = TIMEOUT != 0;
`endif

    always_ff @(posedge clk_fs or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            fx_cnt_q  <= '0;
            fs_cnt_q  <= '0;
            ovf_q     <= 1'b0;
            fx_res_q  <= '0;
            fs_res_q  <= '0;
            ovf_res_q <= 1'b0;
            busy_q    <= 1'b0;
            gate_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            fx_cnt_q  <= fx_cnt_d;
            fs_cnt_q  <= fs_cnt_d;
            ovf_q     <= ovf_d;
            fx_res_q  <= fx_res_d;
            fs_res_q  <= fs_res_d;
            ovf_res_q <= ovf_res_d;
            busy_q    <= state_d != IDLE;
            gate_q    <= state_d == GATE;
            done_q    <= state_d == DONE;
            timeout_q <= to_hit;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.gate      = gate_q;
    assign bus.done      = done_q;
    assign bus.timeout   = timeout_q;
    assign bus.fx_result = fx_res_q;
    assign bus.fs_result = fs_res_q;
    assign bus.ovf       = ovf_res_q;
endmodule

// File: tb/tb_gate_ctrl.sv
// tb_gate_ctrl: randomized and directed checks of gate_ctrl against an arithmetic model
// of gate length, reference-cycle count and saturation (32-bit and 8-bit counter builds).
module tb_gate_ctrl;
    localparam int TO = 1000;

    logic        clk_fs = 1'b0;
    logic        rst = 1'b1;
    logic        clk_fx = 1'b0;
    logic        start = 1'b0;
    logic        cont = 1'b0;
    logic [15:0] gate_len = '0;
    logic        sel = 1'b0;
    logic        fx_en = 1'b1;
    int          fx_half = 50;
    int          checks = 0;
    int          failures = 0;
    int          done_cnt = 0;
    int          to_cnt = 0;

    gate_if #(.CNT_W(32), .GATE_W(16)) bus ();
    gate_if #(.CNT_W(8),  .GATE_W(16)) bus8 ();

    assign bus.clk_fx    = clk_fx;
    assign bus.start     = start & ~sel;
    assign bus.cont      = cont;
    assign bus.gate_len  = gate_len;
    assign bus8.clk_fx   = clk_fx;
    assign bus8.start    = start & sel;
    assign bus8.cont     = cont;
    assign bus8.gate_len = gate_len;

    gate_ctrl #(.CNT_W(32), .GATE_W(16), .SYNC_STAGES(2), .TIMEOUT(TO)) dut (
        .clk_fs (clk_fs),
        .rst    (rst),
        .bus    (bus)
    );
    gate_ctrl #(.CNT_W(8), .GATE_W(16), .SYNC_STAGES(2), .TIMEOUT(TO)) dut8 (
        .clk_fs (clk_fs),
        .rst    (rst),
        .bus    (bus8)
    );

    logic   obs_done, obs_busy, obs_gate, obs_ovf, obs_to;
    longint obs_fx, obs_fs;
    assign obs_done = sel ? bus8.done : bus.done;
    assign obs_busy = sel ? bus8.busy : bus.busy;
    assign obs_gate = sel ? bus8.gate : bus.gate;
    assign obs_ovf  = sel ? bus8.ovf : bus.ovf;
    assign obs_to   = sel ? bus8.timeout : bus.timeout;
    assign obs_fx   = sel ? longint'(bus8.fx_result) : longint'(bus.fx_result);
    assign obs_fs   = sel ? longint'(bus8.fs_result) : longint'(bus.fs_result);

    initial forever #5 clk_fs = ~clk_fs;

    // edges land 2 units after a multiple of 10, never on a clk_fs edge
    initial begin
        #2;
        forever begin
            #(fx_half);
            clk_fx = fx_en ? ~clk_fx : 1'b0;
        end
    end

    always @(negedge clk_fs) begin
        if (bus.done | bus8.done) done_cnt++;
        if (bus.timeout | bus8.timeout) to_cnt++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input longint got, input longint exp, input longint tol = 0);
        checks++;
        if (got > exp + tol || got < exp - tol) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d tol=%0d", tag, got, exp, tol);
        end
    endtask

    task automatic wait_done(input int budget, output bit hit, output int n);
        hit = 1'b0;
        n = 0;
        while (!hit && n < budget) begin
            @(negedge clk_fs);
            n++;
            hit = obs_done;
        end
    endtask

    task automatic pulse_start(input string tag);
        start = 1'b1;
        @(negedge clk_fs);
        start = 1'b0;
        check({tag, "_busy_rise"}, obs_busy, 1);
    endtask

    task automatic settle(input int half);
        fx_half = half;
        #(4 * half);
        @(negedge clk_fs);
    endtask

    // expected results follow from the gate spanning max(len,1) periods of 2*half time units
    task automatic run_one(input string tag, input int len, input int half);
        longint nl, cyc, maxc;
        bit     hit;
        int     n;
        nl   = (len == 0) ? 1 : len;
        cyc  = nl * 2 * half / 10;
        maxc = sel ? 255 : 64'hFFFF_FFFF;
        gate_len = 16'(len);
        cont = 1'b0;
        settle(half);
        pulse_start(tag);
        wait_done(int'(cyc) + 6 * half / 10 + 50, hit, n);
        check({tag, "_done"}, hit, 1);
        check({tag, "_fx"}, obs_fx, nl);
        check({tag, "_fs"}, obs_fs, cyc > maxc ? maxc : cyc, cyc > maxc ? 0 : 1);
        check({tag, "_ovf"}, obs_ovf, cyc > maxc ? 1 : 0);
        check({tag, "_gate_at_done"}, obs_gate, 0);
        @(negedge clk_fs);
        check({tag, "_busy_fall"}, obs_busy, 0);
    endtask

    initial begin
        bit     hit;
        int     n, d0, t0;
        longint fx0, fs0;
        repeat (3) @(negedge clk_fs);
        check("rst_gate", bus.gate, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done | bus.timeout, 0);
        check("rst_fx", bus.fx_result, 0);
        check("rst_fs", bus.fs_result, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk_fs);

        run_one("f10m_len5", 5, 50);
        run_one("f1m_len0", 0, 500);
        for (int i = 0; i < 6; i++) run_one($sformatf("rnd%0d", i), int'($urandom_range(0, 8)), 10 * int'($urandom_range(3, 10)));

        gate_len = 16'd4;
        cont = 1'b1;
        settle(100);
        pulse_start("cont");
        wait_done(400, hit, n);
        check("cont_first_done", hit, 1);
        for (int k = 0; k < 3; k++) begin
            if (k == 2) begin
                repeat (10) @(negedge clk_fs);
                cont = 1'b0;
                wait_done(200, hit, n);
                n += 10;
            end else begin
                wait_done(200, hit, n);
            end
            check($sformatf("cont%0d_done", k), hit, 1);
            check($sformatf("cont%0d_spacing", k), n, 100, 1);
            check($sformatf("cont%0d_fx", k), obs_fx, 4);
            check($sformatf("cont%0d_fs", k), obs_fs, 80, 1);
        end
        @(negedge clk_fs);
        check("cont_stop_busy", obs_busy, 0);
        d0 = done_cnt;
        repeat (300) @(negedge clk_fs);
        check("cont_no_extra_done", done_cnt, d0);

        sel = 1'b1;
        run_one("sat8", 10, 500);
        sel = 1'b0;

        fx_en = 1'b0;
        repeat (20) @(negedge clk_fs);
        fx0 = obs_fx;
        fs0 = obs_fs;
        d0 = done_cnt;
        t0 = to_cnt;
        pulse_start("nosig");
`ifdef GATE_TIMEOUT_EN
        hit = 1'b0;
        n = 0;
        while (!hit && n < TO + 200) begin
            @(negedge clk_fs);
            n++;
            hit = obs_to;
        end
        check("to_pulse", hit, 1);
        check("to_latency", n, TO, 1);
        check("to_busy", obs_busy, 0);
        @(negedge clk_fs);
        check("to_one_cycle", obs_to, 0);
        check("to_no_done", done_cnt, d0);
        check("to_fx_kept", obs_fx, fx0);
        check("to_fs_kept", obs_fs, fs0);
`else
        repeat (TO + 200) @(negedge clk_fs);
        check("nosig_no_timeout", to_cnt, t0);
        check("nosig_still_busy", obs_busy, 1);
        check("nosig_no_done", done_cnt, d0);
        check("nosig_fx_kept", obs_fx, fx0);
        rst = 1'b1;
        @(negedge clk_fs);
        rst = 1'b0;
`endif
        fx_en = 1'b1;

        gate_len = 16'd8;
        settle(100);
        run_one("pre_rst", 3, 100);
        gate_len = 16'd8;
        pulse_start("mid_rst");
        n = 0;
        while (!obs_gate && n < 200) begin
            @(negedge clk_fs);
            n++;
        end
        check("mid_rst_gate_open", obs_gate, 1);
        repeat (20) @(negedge clk_fs);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_gate", obs_gate, 0);
        check("mid_rst_busy", obs_busy, 0);
        check("mid_rst_fx", obs_fx, 0);
        check("mid_rst_fs", obs_fs, 0);
        d0 = done_cnt;
        @(negedge clk_fs);
        rst = 1'b0;
        repeat (3) @(negedge clk_fs);
        check("mid_rst_no_done", done_cnt, d0);
        run_one("post_rst", 3, 50);

        check("no_spurious_timeout", to_cnt, `ifdef GATE_TIMEOUT_EN t0 + 1 `else t0 `endif);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
